mux_stream_rr: RTL and testbench

Parametrised N-channel, W-bit registered stream multiplexer with valid/ready handshakes on every input and on the output. It generalises the team's combinational 16:1 single-bit mux in three ways: multi-bit data, any channel count, and a runtime-selectable arbitration mode (fixed select, fixed priority, round-robin). It sits between multiple producer streams and a single consumer, with one output register stage.

---
 rtl/mux_stream_rr.sv | 95 +++++++++
 tb/tb_mux_stream_rr.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mux_stream_rr.sv
// N-channel registered stream multiplexer with valid/ready handshakes and a
// runtime-selectable arbitration mode (fixed select, fixed priority, round-robin).
module mux_stream_rr #(
    parameter int N_CH   = 16,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_valid,
    output logic [N_CH-1:0]          in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready
);

    logic [SEL_W-1:0]  last_grant_r;
    logic [SEL_W-1:0]  grant_s;
    logic              grant_vld_s;
    logic              load_en_s;
    logic [DATA_W-1:0] grant_data_s;
    int                best_dist_s;
    int                dist_s;
    logic              take_s;

    assign load_en_s = !out_valid || out_ready;

    // Grant selection; round-robin picks the valid channel at the smallest
    // forward distance from last_grant (last_grant itself is distance N_CH).
    always_comb begin
        grant_s     = '0;
        grant_vld_s = 1'b0;
        best_dist_s = N_CH + 1;
        dist_s      = 0;
        take_s      = 1'b0;
        case (mode)
            2'd1: begin
                for (int i = N_CH - 1; i >= 0; i--) begin
                    grant_s     = in_valid[i] ? SEL_W'(i) : grant_s;
                    grant_vld_s = grant_vld_s | in_valid[i];
                end
            end
            2'd2: begin
                for (int i = 0; i < N_CH; i++) begin
                    dist_s      = (i > int'(last_grant_r)) ? (i - int'(last_grant_r))
                                                           : (i - int'(last_grant_r) + N_CH);
                    take_s      = in_valid[i] && (dist_s < best_dist_s);
                    best_dist_s = take_s ? dist_s : best_dist_s;
                    grant_s     = take_s ? SEL_W'(i) : grant_s;
                    grant_vld_s = grant_vld_s | in_valid[i];
                end
            end
            default: begin
                // Only indices below N_CH are compared, so an out-of-range sel never grants.
                for (int i = 0; i < N_CH; i++) begin
                    take_s      = (sel == SEL_W'(i)) && in_valid[i];
                    grant_s     = take_s ? SEL_W'(i) : grant_s;
                    grant_vld_s = grant_vld_s | take_s;
                end
            end
        endcase
    end

    // Data mux and per-channel ready; ready is held low while in reset.
    always_comb begin
        grant_data_s = '0;
        in_ready     = '0;
        for (int i = 0; i < N_CH; i++) begin
            grant_data_s = (grant_s == SEL_W'(i)) ? in_data[i*DATA_W +: DATA_W] : grant_data_s;
            in_ready[i]  = rst_n && load_en_s && grant_vld_s && (grant_s == SEL_W'(i));
        end
    end

    // Output register stage and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_ch       <= '0;
            last_grant_r <= SEL_W'(N_CH - 1);
        end else if (load_en_s) begin
            out_valid <= grant_vld_s;
            if (grant_vld_s) begin
                out_data     <= grant_data_s;
                out_ch       <= grant_s;
                last_grant_r <= grant_s;
            end
        end
    end

endmodule

// File: tb/tb_mux_stream_rr.sv
// Scoreboard bench for mux_stream_rr: a reference arbiter predicts each accepted
// beat, and a monitor compares every presented output beat against the queue.
module tb_mux_stream_rr;
    localparam int N_CH   = 20;
    localparam int DATA_W = 8;
    localparam int SEL_W  = $clog2(N_CH);

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [1:0]             mode;
    logic [SEL_W-1:0]       sel;
    logic [N_CH*DATA_W-1:0] in_data;
    logic [N_CH-1:0]        in_valid;
    logic [N_CH-1:0]        in_ready;
    logic [DATA_W-1:0]      out_data;
    logic [SEL_W-1:0]       out_ch;
    logic                   out_valid;
    logic                   out_ready;

    mux_stream_rr #(.N_CH(N_CH), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] d;
        int                ch;
    } beat_t;

    beat_t             sbq[$];
    logic [DATA_W-1:0] dat [N_CH];
    int                vectors = 0;
    int                errors  = 0;
    int                m_last;
    bit                m_valid;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference arbiter: returns granted channel or -1.
    function automatic int ref_grant(int md, int s, logic [N_CH-1:0] v, int last);
        if (md == 1) begin
            for (int i = 0; i < N_CH; i++) if (v[i]) return i;
            return -1;
        end
        if (md == 2) begin
            for (int k = 1; k <= N_CH; k++) if (v[(last + k) % N_CH]) return (last + k) % N_CH;
            return -1;
        end
        if (s < N_CH) begin
            if (v[s]) return s;
        end
        return -1;
    endfunction

    task automatic model_reset();
        sbq.delete();
        m_valid = 1'b0;
        m_last  = N_CH - 1;
    endtask

    // Apply one cycle of stimulus (called at a falling edge), check the
    // combinational ready and the held valid, then predict the next edge.
    task automatic step(input int md, input int s, input logic [N_CH-1:0] v, input logic ordy);
        int              g;
        bit              ld;
        logic [N_CH-1:0] exp_rdy;
        beat_t           b;
        mode      = md[1:0];
        sel       = SEL_W'(s);
        in_valid  = v;
        out_ready = ordy;
        for (int i = 0; i < N_CH; i++) in_data[i*DATA_W +: DATA_W] = dat[i];
        #1;
        ld      = !m_valid || ordy;
        g       = ref_grant(md, s, v, m_last);
        exp_rdy = '0;
        if (ld && g >= 0) exp_rdy[g] = 1'b1;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check("out_valid", 64'(out_valid), 64'(m_valid));
        if (ld) begin
            if (g >= 0) begin
                b.d  = dat[g];
                b.ch = g;
                sbq.push_back(b);
                m_valid = 1'b1;
                m_last  = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    // Monitor: every presented beat must match the head of the scoreboard.
    always @(posedge clk) begin
        if (rst_n && out_valid) begin
            vectors++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL beat: unexpected ch=%0d data=%h, expected none", out_ch, out_data);
            end else begin
                if (out_data !== sbq[0].d || out_ch !== SEL_W'(sbq[0].ch)) begin
                    errors++;
                    $display("FAIL beat: got ch=%0d data=%h, expected ch=%0d data=%h",
                             out_ch, out_data, sbq[0].ch, sbq[0].d);
                end
                if (out_ready) void'(sbq.pop_front());
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        mode      = 2'd0;
        sel       = '0;
        in_valid  = '1;
        out_ready = 1'b1;
        for (int i = 0; i < N_CH; i++) dat[i] = DATA_W'(i);
        for (int i = 0; i < N_CH; i++) in_data[i*DATA_W +: DATA_W] = dat[i];
        model_reset();

        // Reset/idle with all channels requesting
        repeat (3) begin
            @(negedge clk);
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_out_data", 64'(out_data), 64'd0);
            check("rst_out_ch", 64'(out_ch), 64'd0);
            check("rst_in_ready", 64'(in_ready), 64'd0);
        end
        rst_n = 1'b1;

        // Fixed select, then unmatched and out-of-range sel
        dat[5] = 8'hA5;
        step(0, 5, 20'h00020, 1'b1);
        step(0, 5, 20'h00000, 1'b1);
        step(0, 17, 20'h00020, 1'b1);
        step(0, 17, 20'h00020, 1'b1);
        step(0, 25, 20'hFFFFF, 1'b1);
        step(3, 30, 20'hFFFFF, 1'b1);
        step(3, 19, 20'h80000, 1'b1);
        step(0, 19, 20'h00000, 1'b1);

        // Fixed priority: 4 while valid, then 7, then 15
        for (int i = 0; i < 3; i++) step(1, 0, 20'h08090, 1'b1);
        for (int i = 0; i < 2; i++) step(1, 0, 20'h08080, 1'b1);
        for (int i = 0; i < 2; i++) step(1, 0, 20'h08000, 1'b1);

        // Round-robin over 16 valid channels
        for (int i = 0; i < N_CH; i++) dat[i] = DATA_W'(i);
        for (int i = 0; i < 20; i++) step(2, 0, 20'h0FFFF, 1'b1);

        // Backpressure hold, then release without a bubble
        for (int i = 0; i < 4; i++) step(2, 0, 20'h0FFFF, 1'b0);
        for (int i = 0; i < 3; i++) step(2, 0, 20'h0FFFF, 1'b1);

        // Asynchronous reset while a beat is held
        step(2, 0, 20'h0FFFF, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(2, 0, 20'h0FFF0, 1'b1);

        // Randomized modes, selects, requests and backpressure
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N_CH; i++) dat[i] = DATA_W'($urandom);
            step($urandom_range(0, 3), $urandom_range(0, 31),
                 N_CH'($urandom & $urandom), ($urandom_range(0, 3) != 0));
        end

        // Drain and confirm every predicted beat was seen
        for (int i = 0; i < 4; i++) step(1, 0, 20'h00000, 1'b1);
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
